// File: rtl/seven_segment_pkg.sv
// Shared constants for the seconds counter: counter width, reset compare, segment patterns.
// Latency: n/a (constants only).
// Backpressure: n/a.
package seven_segment_pkg;

    localparam int unsigned COUNTER_W = 24;

    // One real second at a 16 MHz user clock.
    localparam logic [COUNTER_W-1:0] DEFAULT_COMPARE = 24'd16_000_000;

    // Segment patterns {g,f,e,d,c,b,a}; 1 = segment lit (common cathode).
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111100;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1100111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seven_segment_seconds_if.sv
// Bus bundle for the seconds display: compare load strobe in, segment drive out.
// Latency: n/a (wires only).
// Backpressure: none; the strobe is accepted unconditionally.
interface seven_segment_seconds_if;
    import seven_segment_pkg::*;

    logic [COUNTER_W-1:0] compare_in;
    logic                 update_compare;
    logic [6:0]           led_out;
    logic [6:0]           led_oeb;

    // Controller side: loads a new period and watches the display pads.
    modport master (
        output compare_in,
        output update_compare,
        input  led_out,
        input  led_oeb
    );

    // Display block side.
    modport slave (
        input  compare_in,
        input  update_compare,
        output led_out,
        output led_oeb
    );

endinterface

// File: rtl/seg7_decoder.sv
// Maps a BCD digit to its common-cathode seven-segment pattern.
// Latency: purely combinational.
// Backpressure: none.
module seg7_decoder
    import seven_segment_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Digit-to-segment lookup; codes 10-15 never occur but blank the display if they do.
    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_segment_seconds.sv
// Counts clock cycles up to a programmable compare value and steps a 0-9 digit on each tick.
// Latency: led_out follows the digit register combinationally (same cycle as the digit update).
// Backpressure: none; update_compare is a single-cycle strobe taken immediately.
module seven_segment_seconds
    import seven_segment_pkg::*;
(
    input  logic                   clock,
    input  logic                   resetb,
    seven_segment_seconds_if.slave bus
);

    logic [COUNTER_W-1:0] counter_q, counter_d;
    logic [COUNTER_W-1:0] compare_q, compare_d;
    logic [3:0]           digit_q,   digit_d;

    logic [COUNTER_W:0]   count_inc;
    logic                 tick;
    logic [6:0]           seg_pat;

    // Tick test is one bit wider than the counter so counter+1 can never wrap.
    // Using >= also makes compare values of 0 and 1 tick every cycle.
    always_comb begin
        count_inc = {1'b0, counter_q} + {{COUNTER_W{1'b0}}, 1'b1};
        tick      = (count_inc >= {1'b0, compare_q});
    end

    // Next-state: a compare load restarts the period; otherwise tick or keep counting.
    always_comb begin
        counter_d = counter_q;
        compare_d = compare_q;
        digit_d   = digit_q;
        if (bus.update_compare) begin
            compare_d = bus.compare_in;
            counter_d = '0;
        end else if (tick) begin
            counter_d = '0;
            digit_d   = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
        end else begin
            counter_d = count_inc[COUNTER_W-1:0];
        end
    end

    // State registers with synchronous active-low reset back to digit 0 and the 1 s period.
    always_ff @(posedge clock) begin
        if (!resetb) begin
            counter_q <= '0;
            compare_q <= DEFAULT_COMPARE;
            digit_q   <= 4'd0;
        end else begin
            counter_q <= counter_d;
            compare_q <= compare_d;
            digit_q   <= digit_d;
        end
    end

    seg7_decoder u_dec (
        .digit (digit_q),
        .seg   (seg_pat)
    );

    assign bus.led_out = seg_pat;
    assign bus.led_oeb = 7'b0000000;

endmodule

// File: tb/tb_seven_segment_seconds.sv
// Scoreboard bench: stimulus queues expected (pattern, cycle) display changes, a monitor checks them.
// Latency: expects each digit change exactly at the edge the period arithmetic predicts.
// Backpressure: n/a.
module tb_seven_segment_seconds;
    import seven_segment_pkg::*;

    typedef struct {
        logic [6:0] pat;
        int         cyc;
    } exp_t;

    // Hand-written display table, independent of the package constants.
    localparam logic [6:0] SEG_TBL [10] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
        7'b1101101, 7'b1111100, 7'b0000111, 7'b1111111, 7'b1100111
    };
    localparam int TB_DEFAULT_COMPARE = 16_000_000;

    logic clock  = 1'b0;
    logic resetb = 1'b0;
    always #5 clock = ~clock;

    seven_segment_seconds_if bus();

    seven_segment_seconds dut (
        .clock  (clock),
        .resetb (resetb),
        .bus    (bus)
    );

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   exp_digit = 0;
    bit   mon_en = 1'b0;
    logic [6:0] prev;
    exp_t q[$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every change of the display must match the next queued expectation.
    always @(negedge clock) begin
        exp_t e;
        if (mon_en && (bus.led_out !== prev)) begin
            if (q.size() == 0) begin
                chk("unexpected_change", int'(bus.led_out), int'(prev));
            end else begin
                e = q.pop_front();
                chk("seg_pattern", int'(bus.led_out), int'(e.pat));
                chk("tick_cycle", cyc, e.cyc);
            end
            prev = bus.led_out;
        end
    end

    task automatic push_tick(input int at);
        exp_t e;
        exp_digit = (exp_digit + 1) % 10;
        e.pat = SEG_TBL[exp_digit];
        e.cyc = at;
        q.push_back(e);
    endtask

    // Load a compare value; returns at the negedge after the edge that sampled it.
    task automatic strobe(input int v);
        bus.compare_in     = COUNTER_W'(v);
        bus.update_compare = 1'b1;
        @(negedge clock);
        bus.update_compare = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk(name, q.size(), 0);
        q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        bus.compare_in     = '0;
        bus.update_compare = 1'b0;

        // Reset held for four edges.
        repeat (4) @(negedge clock);
        chk("reset_led_out", int'(bus.led_out), int'(7'b0111111));
        chk("reset_led_oeb", int'(bus.led_oeb), 0);
        resetb = 1'b1;
        chk("reset_compare", int'(dut.compare_q), TB_DEFAULT_COMPARE);
        prev   = bus.led_out;
        mon_en = 1'b1;
        repeat (200) @(negedge clock);

        // Full sequence and wrap with a 100-cycle period: ten ticks, 1000 cycles.
        strobe(100);
        s = cyc;
        for (int i = 1; i <= 10; i++) push_tick(s + 100 * i);
        wait_drain("drain_period100", 1100);

        // Period 1: one tick per cycle.
        strobe(1);
        s = cyc;
        for (int i = 1; i <= 12; i++) push_tick(s + i);
        repeat (12) @(negedge clock);
        strobe(1000);
        wait_drain("drain_period1", 20);

        // Period 0 behaves like period 1.
        strobe(0);
        s = cyc;
        for (int i = 1; i <= 11; i++) push_tick(s + i);
        repeat (11) @(negedge clock);
        strobe(1000);
        wait_drain("drain_period0", 20);

        // Period 2: tick every second cycle.
        strobe(2);
        s = cyc;
        for (int i = 1; i <= 6; i++) push_tick(s + 2 * i);
        repeat (12) @(negedge clock);
        strobe(1000);
        wait_drain("drain_period2", 20);

        // Mid-count reload: counter at 50 of 100, then load 10.
        strobe(100);
        repeat (50) @(negedge clock);
        strobe(10);
        s = cyc;
        push_tick(s + 10);
        while (exp_digit != 7) push_tick(s + 10 * (q.size() + 1));
        wait_drain("drain_midcount", 200);

        // Reset in the middle of a period while showing 7.
        repeat (3) @(negedge clock);
        resetb = 1'b0;
        begin
            exp_t e;
            e.pat = SEG_TBL[0];
            e.cyc = cyc + 1;
            q.push_back(e);
            exp_digit = 0;
        end
        @(negedge clock);
        resetb = 1'b1;
        chk("midreset_compare", int'(dut.compare_q), TB_DEFAULT_COMPARE);
        repeat (30) @(negedge clock);
        chk("final_queue_empty", q.size(), 0);
        chk("final_led_out", int'(bus.led_out), int'(7'b0111111));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seven_segment_seconds.md
Name: seven_segment_seconds

Overview:
User-project block that counts elapsed "seconds" and shows the current decimal digit (0-9) on a common-cathode seven-segment display. It is driven from the user-area clock. Its 7 segment outputs leave the chip on mprj_io[14:8], with led_out[0] on mprj_io[8]. A programmable compare value sets the tick period, so simulation can use short periods and silicon can use a real 1 s period.

Parameters:
COUNTER_W, 24, width of the tick counter and of the compare value
DEFAULT_COMPARE, 24'd16_000_000, compare value loaded at reset (1 s at 16 MHz)

Ports:
clock  input  1  user-area clock; all state changes on its rising edge
resetb  input  1  reset; synchronous, active-low
compare_in  input  COUNTER_W  new tick period in clock cycles
update_compare  input  1  single-cycle strobe that loads compare_in
led_out  output  7  segment drive {g,f,e,d,c,b,a}; bit0 = segment a; 1 = lit
led_oeb  output  7  pad output-enable bar; constant 7'b0000000 (always driving)

Behaviour:
- Reset (resetb low at a rising edge):
  - counter <= 0
  - digit <= 0
  - compare <= DEFAULT_COMPARE
  - led_out shows the pattern for 0, i.e. 7'b0111111
- State: counter (COUNTER_W bits), digit (4 bits, range 0-9), compare (COUNTER_W bits).
- Per cycle, with resetb high, in priority order:
  1. update_compare = 1: compare <= compare_in; counter <= 0; digit unchanged.
  2. Else tick condition (counter + 1 >= compare, evaluated at COUNTER_W+1 bits so nothing overflows): counter <= 0, and digit advances by 1, with 9 wrapping to 0.
  3. Else counter <= counter + 1.
- Tick period is exactly max(compare, 1) cycles. compare = 0 or 1 ticks every cycle.
- If a new compare is smaller than the current counter, the tick fires on the next cycle. This case only arises if compare is changed without a counter clear, which cannot happen through update_compare, but the >= comparison covers it anyway.
- led_out is a combinational decode of the registered digit. It changes in the same cycle digit updates, with no extra latency.
- Segment encodings, led_out[6:0]:
  - 0 = 0111111
  - 1 = 0000110
  - 2 = 1011011
  - 3 = 1001111
  - 4 = 1100110
  - 5 = 1101101
  - 6 = 1111100 (no segment a)
  - 7 = 0000111
  - 8 = 1111111
  - 9 = 1100111 (no segment d)
- Illegal digit values 10-15 cannot occur. The decoder still maps them to 0000000 (blank) as a safety default.
- Reset mid-count overrides everything: digit returns to 0 and compare returns to DEFAULT_COMPARE even if a custom compare had been loaded.
- update_compare and reset in the same cycle: reset wins.

Decomposition:
- Package seven_segment_pkg holds:
  - COUNTER_W
  - DEFAULT_COMPARE
  - the ten SEG_0..SEG_9 7-bit localparam patterns
  - SEG_BLANK
- One sub-module, seg7_decoder: 4-bit digit in, 7-bit pattern out, purely combinational.
- Counter, compare register and digit register live in the top module.

Test Plan:
- Reset: hold resetb low for 4 cycles -> led_out = 0111111, led_oeb = 0000000; after release, no digit change before DEFAULT_COMPARE cycles.
- Full sequence: after reset, pulse update_compare with compare_in = 100 -> led_out steps through 0111111, 0000110, 1011011, 1001111, 1100110, 1101101, 1111100, 0000111, 1111111, 1100111, with each digit held exactly 100 cycles.
- Wrap: continue from the previous scenario -> after 1100111 (9), the next tick gives 0111111 (0); the full 10-digit cycle takes 1000 cycles.
- Compare edge values:
  - compare_in = 1 -> digit advances every cycle.
  - compare_in = 0 -> same behaviour as 1.
  - compare_in = 2 -> digit advances every 2nd cycle.
- Mid-count update: with compare = 100 and counter at 50, load compare_in = 10 -> the next tick comes exactly 10 cycles after the strobe, and the digit does not change on the strobe cycle.
- Reset mid-operation: at digit 7 with compare = 10, pull resetb low for one edge -> led_out = 0111111 and compare = DEFAULT_COMPARE; no tick within 10 cycles after release.
